// File: rtl/alu_sched.sv
// ---------------------------------------------------------------------------
// alu_sched
//
// Round-robin front end for the shared 8-bit ALU. Up to NUM_REQ requesters
// post operations over a valid/ready handshake. One operation at a time is
// granted, its fields are registered onto the ALU inputs, and the ALU result
// is captured after ALU_LATENCY cycles. The result is then returned to the
// granted requester over a second valid/ready handshake.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   ALU_LATENCY  cycles from stable ALU inputs to valid result (0 = comb ALU)
//
// Ports
//   clk, reset             clock and synchronous active-high reset
//   req_valid/req_ready    per-requester operation handshake
//   req_op_code            4 bits per requester, requester i at [4i+3:4i]
//   req_operand_1/2        8 bits per requester, requester i at [8i+7:8i]
//   req_shift_rotate       3 bits per requester, requester i at [3i+2:3i]
//   rsp_valid/rsp_ready    per-requester response handshake
//   rsp_result, rsp_carry  shared response bus, valid while rsp_valid != 0
//   busy                   high whenever the scheduler is not idle
//   op_code, operand_1, operand_2, shift_rotate   registered ALU inputs
//   result, carry          ALU outputs
// ---------------------------------------------------------------------------
module alu_sched #(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_op_code,
    input  logic [8*NUM_REQ-1:0]   req_operand_1,
    input  logic [8*NUM_REQ-1:0]   req_operand_2,
    input  logic [3*NUM_REQ-1:0]   req_shift_rotate,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [7:0]             rsp_result,
    output logic                   rsp_carry,
    output logic                   busy,
    output logic [3:0]             op_code,
    output logic [7:0]             operand_1,
    output logic [7:0]             operand_2,
    output logic [2:0]             shift_rotate,
    input  logic [7:0]             result,
    input  logic                   carry
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant;
    logic [PTR_W-1:0]   winner;
    logic               win_found;
    logic [CNT_W-1:0]   cnt;
    int unsigned        cand;

    // Round-robin search starting at ptr. The candidate index wraps by a
    // single subtraction instead of a modulo, since ptr + k < 2*NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                winner    = PTR_W'(cand);
            end
        end
    end

    // Accept is only offered while idle, and only to the search winner.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Main scheduler FSM. In IDLE a found winner is always a completed
    // handshake, because req_ready[winner] is raised in that same cycle.
    // The ALU input registers are only written on a handshake so they keep
    // the last issued operation between requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            grant        <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            rsp_valid    <= '0;
            rsp_result   <= 8'h00;
            rsp_carry    <= 1'b0;
            op_code      <= 4'h0;
            operand_1    <= 8'h00;
            operand_2    <= 8'h00;
            shift_rotate <= 3'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant        <= winner;
                        op_code      <= req_op_code[4*winner +: 4];
                        operand_1    <= req_operand_1[8*winner +: 8];
                        operand_2    <= req_operand_2[8*winner +: 8];
                        shift_rotate <= req_shift_rotate[3*winner +: 3];
                        cnt          <= CNT_W'(ALU_LATENCY);
                        busy         <= 1'b1;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_result <= result;
                        rsp_carry  <= carry;
                        rsp_valid  <= NUM_REQ'(1) << grant;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    // Only the granted requester's ready matters here.
                    if (rsp_ready[grant]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        ptr       <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_sched
//
// Bench for alu_sched. Instance dut0 uses a combinational ALU model
// (ALU_LATENCY=0); instance dut3 uses ALU_LATENCY=3 with an ALU model that
// shows 8'hAA until its inputs have been stable for three cycles, then 8'h55.
// Expected responses of dut0 are queued on each request handshake and
// compared when the response handshake happens.
// ---------------------------------------------------------------------------
module tb_alu_sched;

    localparam int N = 4;

    typedef struct packed {
        int         idx;
        logic [7:0] res;
        logic       c;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // dut0 signals
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_op_code;
    logic [8*N-1:0] req_operand_1;
    logic [8*N-1:0] req_operand_2;
    logic [3*N-1:0] req_shift_rotate;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [7:0]     rsp_result;
    logic           rsp_carry;
    logic           busy;
    logic [3:0]     op_code;
    logic [7:0]     operand_1;
    logic [7:0]     operand_2;
    logic [2:0]     shift_rotate;
    logic [7:0]     alu_result;
    logic           alu_carry;
    logic [8:0]     alu_out;

    // dut3 signals
    logic [N-1:0]   l_req_valid;
    logic [N-1:0]   l_req_ready;
    logic [4*N-1:0] l_req_op_code;
    logic [8*N-1:0] l_req_operand_1;
    logic [8*N-1:0] l_req_operand_2;
    logic [3*N-1:0] l_req_shift_rotate;
    logic [N-1:0]   l_rsp_valid;
    logic [N-1:0]   l_rsp_ready;
    logic [7:0]     l_rsp_result;
    logic           l_rsp_carry;
    logic           l_busy;
    logic [3:0]     l_op_code;
    logic [7:0]     l_operand_1;
    logic [7:0]     l_operand_2;
    logic [2:0]     l_shift_rotate;
    logic [7:0]     l_result;
    logic           l_carry;
    logic [22:0]    l_in, h0, h1, h2;
    logic           l_stable;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    sb_t  sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   mon_g;
    sb_t  mon_e;
    logic [8:0] mon_out;
    logic [8:0] exp_bp;

    // Bench ALU: op 0 add (carry from the add), 1 subtract (borrow in
    // carry), 2 and, 3 xor with the shift field mixed in, others pass a.
    function automatic logic [8:0] aluModel(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [2:0] sr);
        case (op)
            4'h0:    return {1'b0, a} + {1'b0, b};
            4'h1:    return {1'b0, a} - {1'b0, b};
            4'h2:    return {1'b0, a & b};
            4'h3:    return {1'b0, a ^ b ^ {5'b0, sr}};
            default: return {1'b0, a};
        endcase
    endfunction

    assign alu_out    = aluModel(op_code, operand_1, operand_2, shift_rotate);
    assign alu_result = alu_out[7:0];
    assign alu_carry  = alu_out[8];

    // Latency-3 ALU: result is 8'h55 only once the inputs have been held
    // for three full cycles, 8'hAA otherwise.
    assign l_in = {l_op_code, l_operand_1, l_operand_2, l_shift_rotate};
    always @(posedge clk) begin
        h0 <= l_in;
        h1 <= h0;
        h2 <= h1;
    end
    assign l_stable = (l_in == h0) && (h0 == h1) && (h1 == h2);
    assign l_result = l_stable ? 8'h55 : 8'hAA;
    assign l_carry  = l_stable;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_sched #(.NUM_REQ(N), .ALU_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_code(req_op_code), .req_operand_1(req_operand_1),
        .req_operand_2(req_operand_2), .req_shift_rotate(req_shift_rotate),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .busy(busy),
        .op_code(op_code), .operand_1(operand_1), .operand_2(operand_2),
        .shift_rotate(shift_rotate), .result(alu_result), .carry(alu_carry)
    );

    alu_sched #(.NUM_REQ(N), .ALU_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(l_req_valid), .req_ready(l_req_ready),
        .req_op_code(l_req_op_code), .req_operand_1(l_req_operand_1),
        .req_operand_2(l_req_operand_2), .req_shift_rotate(l_req_shift_rotate),
        .rsp_valid(l_rsp_valid), .rsp_ready(l_rsp_ready),
        .rsp_result(l_rsp_result), .rsp_carry(l_rsp_carry), .busy(l_busy),
        .op_code(l_op_code), .operand_1(l_operand_1), .operand_2(l_operand_2),
        .shift_rotate(l_shift_rotate), .result(l_result), .carry(l_carry)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int i, input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [2:0] sr);
        req_op_code[4*i +: 4]      = op;
        req_operand_1[8*i +: 8]    = a;
        req_operand_2[8*i +: 8]    = b;
        req_shift_rotate[3*i +: 3] = sr;
    endtask

    task automatic waitGrants(input int n);
        int k = 0;
        while (grant_log.size() < n && k < 60) begin
            @(negedge clk);
            k++;
        end
        checkOutput("grant_count", grant_log.size(), n);
    endtask

    task automatic waitReady(input int i);
        int k = 0;
        @(negedge clk);
        while (!req_ready[i] && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("handshake_seen", {31'b0, req_ready[i]}, 1);
    endtask

    task automatic waitIdle();
        int k = 0;
        int pending;
        pending = sb.size() + int'(busy);
        while (pending != 0 && k < 50) begin
            @(negedge clk);
            k++;
            pending = sb.size() + int'(busy);
        end
        checkOutput("drain", pending, 0);
    endtask

    // Scoreboard monitor for dut0: queue on request handshake, compare on
    // response handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if ((req_valid & req_ready) != '0) begin
                mon_g = 0;
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && req_ready[i]) mon_g = i;
                end
                mon_out = aluModel(req_op_code[4*mon_g +: 4], req_operand_1[8*mon_g +: 8],
                                   req_operand_2[8*mon_g +: 8], req_shift_rotate[3*mon_g +: 3]);
                mon_e.idx = mon_g;
                mon_e.res = mon_out[7:0];
                mon_e.c   = mon_out[8];
                sb.push_back(mon_e);
                grant_log.push_back(mon_g);
                grant_cyc.push_back(cyc);
            end
            if ((rsp_valid & rsp_ready) != '0) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_rsp", {28'b0, rsp_valid}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("sb_rsp_valid", {28'b0, rsp_valid}, {28'b0, N'(1) << mon_e.idx});
                    checkOutput("sb_rsp_result", {24'b0, rsp_result}, {24'b0, mon_e.res});
                    checkOutput("sb_rsp_carry", {31'b0, rsp_carry}, {31'b0, mon_e.c});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        req_valid = '0; rsp_ready = '1;
        req_op_code = '0; req_operand_1 = '0; req_operand_2 = '0; req_shift_rotate = '0;
        l_req_valid = '0; l_rsp_ready = '1;
        l_req_op_code = '0; l_req_operand_1 = '0; l_req_operand_2 = '0; l_req_shift_rotate = '0;

        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_ready", {28'b0, req_ready}, 0);
        checkOutput("rst_rsp_valid", {28'b0, rsp_valid}, 0);
        checkOutput("rst_busy", {31'b0, busy}, 0);
        checkOutput("rst_rsp_result", {24'b0, rsp_result}, 0);
        checkOutput("rst_rsp_carry", {31'b0, rsp_carry}, 0);
        checkOutput("rst_op_code", {28'b0, op_code}, 0);
        checkOutput("rst_operand_1", {24'b0, operand_1}, 0);
        checkOutput("rst_operand_2", {24'b0, operand_2}, 0);
        checkOutput("rst_shift_rotate", {29'b0, shift_rotate}, 0);

        // Latency 3 on dut3: result must be the settled 8'h55 at T+5
        @(posedge clk); #1;
        l_req_op_code[3:0] = 4'h0; l_req_operand_1[7:0] = 8'h12; l_req_operand_2[7:0] = 8'h34;
        l_req_valid = 4'b0001;
        @(negedge clk);
        checkOutput("lat_req_ready", {28'b0, l_req_ready}, 4'b0001);
        @(posedge clk); #1 l_req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput("lat_early_valid", {28'b0, l_rsp_valid}, 0);
        end
        @(negedge clk);
        checkOutput("lat_rsp_valid", {28'b0, l_rsp_valid}, 4'b0001);
        checkOutput("lat_rsp_result", {24'b0, l_rsp_result}, 8'h55);
        checkOutput("lat_rsp_carry", {31'b0, l_rsp_carry}, 1);
        @(negedge clk);
        checkOutput("lat_busy_after", {31'b0, l_busy}, 0);

        // Single request on dut0
        @(posedge clk); #1;
        applyStimulus(0, 4'h0, 8'hF0, 8'h20, 3'h0);
        req_valid = 4'b0001;
        @(negedge clk);
        checkOutput("single_req_ready", {28'b0, req_ready}, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        checkOutput("single_operand_1", {24'b0, operand_1}, 8'hF0);
        checkOutput("single_busy", {31'b0, busy}, 1);
        checkOutput("single_early_valid", {28'b0, rsp_valid}, 0);
        @(negedge clk);
        checkOutput("single_rsp_valid", {28'b0, rsp_valid}, 4'b0001);
        checkOutput("single_rsp_result", {24'b0, rsp_result}, 8'h10);
        checkOutput("single_rsp_carry", {31'b0, rsp_carry}, 1);
        @(negedge clk);
        checkOutput("single_valid_drop", {28'b0, rsp_valid}, 0);
        checkOutput("single_busy_drop", {31'b0, busy}, 0);

        // Round-robin with all requesters valid from reset
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            applyStimulus(i, 4'(i), 8'($urandom), 8'($urandom), 3'($urandom));
        end
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sb.delete(); grant_log.delete(); grant_cyc.delete();
        waitGrants(5);
        @(posedge clk); #1 req_valid = '0;
        waitIdle();
        for (int i = 0; i < grant_log.size(); i++) begin
            checkOutput("rr_order", grant_log[i], i % N);
            if (i > 0) checkOutput("rr_gap", grant_cyc[i] - grant_cyc[i-1], 3);
        end

        // Response backpressure on requester 1; requester 0 waits meanwhile
        applyStimulus(1, 4'h1, 8'h40, 8'h55, 3'h2);
        applyStimulus(0, 4'h0, 8'h11, 8'h22, 3'h0);
        exp_bp = aluModel(4'h1, 8'h40, 8'h55, 3'h2);
        rsp_ready = 4'b1101;
        @(posedge clk); #1 req_valid = 4'b0010;
        waitReady(1);
        @(posedge clk); #1 req_valid = 4'b0001;
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!rsp_valid[1] && k < 20);
        end
        checkOutput("bp_rsp_seen", {28'b0, rsp_valid}, 4'b0010);
        checkOutput("bp_rsp_result0", {24'b0, rsp_result}, {24'b0, exp_bp[7:0]});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", {28'b0, rsp_valid}, 4'b0010);
            checkOutput("bp_hold_result", {24'b0, rsp_result}, {24'b0, exp_bp[7:0]});
            checkOutput("bp_hold_req_ready", {28'b0, req_ready}, 0);
        end
        @(posedge clk); #1 rsp_ready = '1;
        @(negedge clk);
        checkOutput("bp_release_valid", {28'b0, rsp_valid}, 4'b0010);
        @(negedge clk);
        checkOutput("bp_idle_busy", {31'b0, busy}, 0);
        checkOutput("bp_idle_req_ready", {28'b0, req_ready}, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        waitIdle();

        // Reset while requester 2 is in EXEC
        applyStimulus(2, 4'h3, 8'h5A, 8'h0F, 3'h5);
        applyStimulus(1, 4'h2, 8'hC3, 8'h3C, 3'h1);
        @(posedge clk); #1 req_valid = 4'b0100;
        waitReady(2);
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_exec_busy", {31'b0, busy}, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete(); grant_log.delete(); grant_cyc.delete();
        req_valid = 4'b0110;
        @(negedge clk);
        checkOutput("mid_rst_rsp_valid", {28'b0, rsp_valid}, 0);
        checkOutput("mid_rst_busy", {31'b0, busy}, 0);
        checkOutput("mid_rst_rsp_result", {24'b0, rsp_result}, 0);
        checkOutput("mid_rst_op_code", {28'b0, op_code}, 0);
        checkOutput("mid_rst_operand_1", {24'b0, operand_1}, 0);
        checkOutput("mid_rst_shift_rotate", {29'b0, shift_rotate}, 0);
        checkOutput("mid_rst_req_ready", {28'b0, req_ready}, 4'b0010);
        waitGrants(2);
        @(posedge clk); #1 req_valid = '0;
        waitIdle();
        for (int i = 0; i < grant_log.size(); i++) begin
            checkOutput("mid_rst_order", grant_log[i], i + 1);
        end

        // Pointer wrap: grant 3, then 0 and 3 valid -> 0 first, then 3
        applyStimulus(3, 4'h0, 8'hFF, 8'h01, 3'h0);
        @(posedge clk); #1 req_valid = 4'b1000;
        waitReady(3);
        @(posedge clk); #1 req_valid = '0;
        waitIdle();
        grant_log.delete(); grant_cyc.delete();
        @(posedge clk); #1 req_valid = 4'b1001;
        waitGrants(2);
        @(posedge clk); #1 req_valid = '0;
        waitIdle();
        checkOutput("wrap_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        checkOutput("wrap_second", (grant_log.size() > 1) ? grant_log[1] : -1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares the single 8-bit ALU among `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU's `op_code`, `operand_1`, `operand_2` and `shift_rotate` inputs from registers. After a fixed ALU latency it captures `result`/`carry` and returns them to the granted requester over a second valid/ready handshake. It sits between the requesting blocks and the ALU, on the ALU clock.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ALU_LATENCY`, default 0: cycles between ALU inputs becoming stable and `result`/`carry` being valid. 0 means the ALU is combinational.
- `clk` in 1: the only clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester operation request.
- `req_ready` out `NUM_REQ`: per-requester accept, at most one bit high.
- `req_op_code` in `4*NUM_REQ`: requester i in bits `[4i+3:4i]`.
- `req_operand_1`, `req_operand_2` in `8*NUM_REQ` each: requester i in bits `[8i+7:8i]`.
- `req_shift_rotate` in `3*NUM_REQ`: requester i in bits `[3i+2:3i]`.
- `rsp_valid` out `NUM_REQ`: result available to requester i, at most one bit high.
- `rsp_ready` in `NUM_REQ`: requester i consumes the result.
- `rsp_result` out 8, `rsp_carry` out 1: shared result bus, meaningful while any `rsp_valid` bit is high.
- `busy` out 1: high whenever state is not IDLE.
- `op_code` out 4, `operand_1` out 8, `operand_2` out 8, `shift_rotate` out 3: ALU inputs, registered.
- `result` in 8, `carry` in 1: ALU outputs.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Round-robin pointer `ptr`, range 0..NUM_REQ-1.
- **IDLE:**
  - Winner g is the first i with `req_valid[i]=1`, searching `ptr`, `ptr+1`, … modulo `NUM_REQ`.
  - `req_ready[g]=1` combinationally; all other bits are 0. With no valid request, all bits are 0.
  - On the handshake (valid && ready), register g, load the ALU input registers from requester g's fields, set `cnt=ALU_LATENCY`, and go to EXEC.
- **EXEC:**
  - ALU input registers hold their values.
  - If `cnt!=0`, decrement `cnt`.
  - If `cnt==0`, capture `result`→`rsp_result` and `carry`→`rsp_carry`, then go to RESP.
- **RESP:**
  - `rsp_valid[g]=1`.
  - When `rsp_ready[g]=1`: set `ptr=(g+1) mod NUM_REQ` and go to IDLE.
  - `rsp_ready` bits other than g are ignored.
- Requester rule: once `req_valid[i]` is raised, requester i holds it and its fields stable until `req_ready[i]`. The scheduler samples fields only in the handshake cycle.
- ALU input registers keep the last issued operation while in IDLE. They do not return to 0.
- `req_ready` is 0 in EXEC and RESP. There is only one outstanding operation, so there are no simultaneous-grant cases.
- Reset values:
  - State IDLE, `ptr=0`, `cnt=0`.
  - `req_ready`, `rsp_valid` and `busy` = 0.
  - `rsp_result=8'h00`, `rsp_carry=0`.
  - `op_code=4'h0`, `operand_1=8'h00`, `operand_2=8'h00`, `shift_rotate=3'h0`.
- Reset mid-operation: the in-flight operation is discarded and no response is issued. The next IDLE grant starts search at index 0.

## Timing
- Handshake in cycle T. ALU inputs are stable from T+1.
- `result` is sampled at the end of cycle T+1+`ALU_LATENCY`.
- `rsp_valid` rises in cycle T+2+`ALU_LATENCY`.
- Minimum issue-to-issue interval, with `rsp_ready` already high: 3+`ALU_LATENCY` cycles. RESP at cycle R with `rsp_ready` high means IDLE at R+1, and a new handshake is possible at R+1.
- `rsp_valid`, `rsp_result` and `rsp_carry` stay stable while `rsp_ready[g]=0`, for any number of cycles.
- `busy` rises the cycle after the handshake and falls the cycle after the response handshake.
- `req_ready` is combinational from `req_valid` and `ptr`. All other outputs are registered.

## Test plan
The bench ALU model treats `op_code` 4'h0 as add and drives `carry` from the add.

- **Single request:** requester 0 issues `op_code=4'h0`, `operand_1=8'hF0`, `operand_2=8'h20`, with `ALU_LATENCY=0` and `rsp_ready=1`. Expect handshake at T, `operand_1=8'hF0` at T+1, and `rsp_valid[0]` at T+2 with `rsp_result=8'h10`, `rsp_carry=1`. `rsp_valid[0]` drops at T+3.
- **Round-robin:** all four `req_valid` are held high continuously from reset. Grants come in order 0,1,2,3,0. Each `rsp_valid` goes only to the granted index, and issues are exactly 3 cycles apart.
- **Response backpressure:** `rsp_ready[1]=0` for 5 cycles after `rsp_valid[1]` rises. `rsp_result` is unchanged and `req_ready` stays all 0 meanwhile. IDLE is reached the cycle after `rsp_ready[1]` rises.
- **Latency parameter:** with `ALU_LATENCY=3`, the bench ALU changes `result` from 8'hAA to 8'h55 exactly 3 cycles after its inputs change. Expect `rsp_result=8'h55` at T+5, never 8'hAA.
- **Reset mid-EXEC:** `reset` is asserted one cycle in EXEC with requester 2 granted. No `rsp_valid` is issued, and all outputs take their reset values. With requesters 1 and 2 valid afterwards, requester 1 is granted first.
- **Pointer wrap:** `NUM_REQ=4`, last grant to 3, then requesters 0 and 3 valid. Expect grant to 0 first, then 3.
